// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction fields into 32-bit P32 words,
// buffers them in a small FIFO and streams them to the instruction-memory
// write port with sequential (wrapping) word addresses. A start/flush FSM
// frames each program load.
// Optional build macro INST_ENC_LINT_EN adds a sticky field-legality flag;
// without it lint_err is tied low and no checking logic exists.

`ifndef ALU_OPCODE
`define ALU_OPCODE 8
`endif
`ifndef REGADDR
`define REGADDR 4
`endif
`ifndef HALF
`define HALF 16
`endif
`ifndef WORD
`define WORD 32
`endif

module inst_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`ALU_OPCODE-1:0] opcode,
    input  logic [`REGADDR-1:0]    rd,
    input  logic [`REGADDR-1:0]    rs,
    input  logic                   isfloat,
    input  logic                   src,
    input  logic [1:0]             dst,
    input  logic [`HALF-1:0]       imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [`WORD-1:0]       out_data,
    output logic                   busy,
    output logic                   done,
    output logic                   lint_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [`WORD-1:0]  mem_q [DEPTH];
    logic [`WORD-1:0]  mem_d [DEPTH];
    logic              done_q, done_d;

    logic              push_s, pop_s, in_ready_s, out_valid_s;
    logic [`WORD-1:0]  word_s;

    // Field packing; the register form zero-fills the low 12 bits.
    function automatic logic [`WORD-1:0] encode_word(
        input logic [`ALU_OPCODE-1:0] f_op,
        input logic [`REGADDR-1:0]    f_rd,
        input logic [`REGADDR-1:0]    f_rs,
        input logic                   f_isfloat,
        input logic                   f_src,
        input logic [1:0]             f_dst,
        input logic [`HALF-1:0]       f_imm
    );
        logic [`WORD-1:0] w;
        if (f_src) begin
            w = {f_op[7:4], f_isfloat, f_src, f_dst, f_rd, f_op[3:0], f_imm};
        end else begin
            w = {f_op[7:4], f_isfloat, f_src, f_dst, f_rd, f_rs, f_op[3:0], 12'h000};
        end
        return w;
    endfunction

    // Handshake qualifiers: in_ready depends only on state and count, never on out_ready.
    always_comb begin
        in_ready_s  = (state_q == ST_RUN) && (count_q < DEPTH_C);
        out_valid_s = (count_q != '0);
        push_s      = in_valid && in_ready_s;
        pop_s       = out_valid_s && out_ready;
        word_s      = encode_word(opcode, rd, rs, isfloat, src, dst, imm);
    end

    // Load-framing FSM; done pulses on the DRAIN->IDLE transition.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (flush) state_d = ST_DRAIN;
                else       state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage, pointers, occupancy and the write-address counter.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_s) begin
            mem_d[wr_ptr_q] = word_s;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        else       rd_ptr_d = rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        if ((state_q == ST_IDLE) && start) addr_d = base_addr;
        else if (pop_s)                    addr_d = addr_q + ADDR_W'(1);
        else                               addr_d = addr_q;
    end

    // State, FIFO and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef INST_ENC_LINT_EN
    logic lint_q, lint_d;

    // Sticky flag for accepted bundles carrying a non-zero unused field; start clears it.
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            lint_d = 1'b0;
        end else if (push_s && ((!src && (imm != 16'h0000)) || (src && (rs != 4'h0)))) begin
            lint_d = 1'b1;
        end else begin
            lint_d = lint_q;
        end
    end

    // Lint flag register.
    always_ff @(posedge clk) begin
        if (!reset_n) lint_q <= 1'b0;
        else          lint_q <= lint_d;
    end

    assign lint_err = lint_q;
`else
    assign lint_err = 1'b0;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = mem_q[rd_ptr_q];
    assign out_addr  = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: stimulus pushes expected words from a
// field-arithmetic reference model; a negedge monitor pops and compares on
// every output transfer. Honours INST_ENC_LINT_EN like the design.
`timescale 1ns/1ps

module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = 12'h000;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  opcode = 8'h00;
    logic [3:0]  rd = 4'h0;
    logic [3:0]  rs = 4'h0;
    logic        isfloat = 1'b0;
    logic        src = 1'b0;
    logic [1:0]  dst = 2'b00;
    logic [15:0] imm = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        lint_err;

    inst_encoder #(.DEPTH(4), .ADDR_W(12)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .isfloat(isfloat), .src(src),
        .dst(dst), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done),
        .lint_err(lint_err)
    );

    initial forever #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [11:0] exp_addr = 12'h000;
    logic        rnd_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] hold_data;
    logic [11:0] hold_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the field layout, using plain shifts and adds.
    function automatic logic [31:0] ref_word(input int op, input int f_rd, input int f_rs,
                                             input int f_isf, input int f_src, input int f_dst,
                                             input int f_imm);
        longint unsigned w;
        w = (longint'(op / 16) << 28) + (longint'(f_isf) << 27) + (longint'(f_src) << 26)
          + (longint'(f_dst) << 24) + (longint'(f_rd) << 20);
        if (f_src != 0) w = w + (longint'(op % 16) << 16) + longint'(f_imm);
        else            w = w + (longint'(f_rs) << 16) + (longint'(op % 16) << 12);
        return 32'(w);
    endfunction

    // Scoreboard monitor: record accepted bundles, compare every popped word.
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid && in_ready)
                exp_q.push_back(ref_word(int'(opcode), int'(rd), int'(rs), int'(isfloat),
                                         int'(src), int'(dst), int'(imm)));
            if (done) done_cnt++;
            if (prev_stall) begin
                check("hold_data", out_data, hold_data);
                check("hold_addr", {20'h0, out_addr}, {20'h0, hold_addr});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {31'h0, out_valid}, 32'h0);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    check("out_addr", {20'h0, out_addr}, {20'h0, exp_addr});
                    exp_addr = exp_addr + 12'h001;
                end
            end
            prev_stall = out_valid && !out_ready;
            hold_data  = out_data;
            hold_addr  = out_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Random backpressure while enabled.
    initial forever begin
        @(posedge clk); #2;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic do_start(input logic [11:0] base);
        start = 1'b1; base_addr = base; exp_addr = base;
        tick();
        start = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic send(input logic [7:0] op, input logic [3:0] f_rd, input logic [3:0] f_rs,
                        input logic f_isf, input logic f_src, input logic [1:0] f_dst,
                        input logic [15:0] f_imm, output int waited);
        logic acc;
        opcode = op; rd = f_rd; rs = f_rs; isfloat = f_isf; src = f_src; dst = f_dst; imm = f_imm;
        in_valid = 1'b1; acc = 1'b0; waited = 0;
        while (!acc && waited < 50) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            tick();
            waited++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rand(output int waited);
        send(8'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             2'($urandom), 16'($urandom), waited);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (done) k = 1000;
            else k++;
        end
        if (k != 1000) check("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    int w;
    int d0;

    initial begin
        tick(); tick();
        // Reset state.
        @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_addr", {20'h0, out_addr}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_lint", {31'h0, lint_err}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        check("idle_in_ready", {31'h0, in_ready}, 32'h0);
        tick();

        // Start and register form.
        do_start(12'h100);
        @(negedge clk);
        check("start_busy", {31'h0, busy}, 32'h1);
        check("start_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        out_ready = 1'b1;
        send(8'h3A, 4'd5, 4'd9, 1'b0, 1'b0, 2'd3, 16'h0000, w);
        @(negedge clk);
        check("reg_valid", {31'h0, out_valid}, 32'h1);
        check("reg_data", out_data, 32'h3359A000);
        check("reg_addr", {20'h0, out_addr}, 32'h100);
        tick();

        // Immediate form at the next address.
        send(8'h17, 4'd2, 4'd0, 1'b1, 1'b1, 2'd1, 16'hBEEF, w);
        @(negedge clk);
        check("imm_data", out_data, 32'h1D27BEEF);
        check("imm_addr", {20'h0, out_addr}, 32'h101);
        tick();
        wait_empty();

        // Backpressure: four fit, the fifth waits for the first pop.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_rand(w);
            check("bp_accept_wait", 32'(w), 32'd1);
        end
        @(negedge clk);
        check("bp_full_ready", {31'h0, in_ready}, 32'h0);
        tick();
        tick();
        out_ready = 1'b1;
        send_rand(w);
        check("bp_fifth_wait", 32'(w), 32'd2);
        wait_empty();

        // Randomized traffic with random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send_rand(w);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        d0 = done_cnt;
        do_flush();
        wait_done();
        tick(); tick();
        check("rand_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("rand_busy_after", {31'h0, busy}, 32'h0);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Address wrap across 0xFFF, then flush.
        do_start(12'hFFF);
        out_ready = 1'b0;
        send_rand(w);
        send_rand(w);
        d0 = done_cnt;
        do_flush();
        @(negedge clk);
        check("drain_in_ready", {31'h0, in_ready}, 32'h0);
        check("wrap_first_addr", {20'h0, out_addr}, 32'hFFF);
        tick();
        out_ready = 1'b1;
        wait_done();
        tick(); tick();
        check("wrap_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("wrap_busy_after", {31'h0, busy}, 32'h0);
        check("wrap_final_addr", {20'h0, out_addr}, 32'h001);

        // Flush with an empty FIFO: DRAIN lasts a single cycle.
        do_start(12'h020);
        tick();
        do_flush();
        @(negedge clk);
        check("eflush_busy1", {31'h0, busy}, 32'h1);
        check("eflush_done1", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("eflush_busy2", {31'h0, busy}, 32'h0);
        check("eflush_done2", {31'h0, done}, 32'h1);
        @(negedge clk);
        check("eflush_done3", {31'h0, done}, 32'h0);
        tick();

        // Reset mid-load discards buffered words.
        do_start(12'h200);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(w);
        do_reset();
        @(negedge clk);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        tick();
        out_ready = 1'b1;
        repeat (8) tick();

`ifdef INST_ENC_LINT_EN
        do_start(12'h300);
        @(negedge clk);
        check("lint_clear0", {31'h0, lint_err}, 32'h0);
        tick();
        send(8'h42, 4'd1, 4'd2, 1'b0, 1'b0, 2'd0, 16'h0001, w);
        @(negedge clk);
        check("lint_set", {31'h0, lint_err}, 32'h1);
        tick();
        do_flush();
        wait_done();
        @(negedge clk);
        check("lint_sticky", {31'h0, lint_err}, 32'h1);
        tick();
        do_start(12'h300);
        @(negedge clk);
        check("lint_start_clear", {31'h0, lint_err}, 32'h0);
        tick();
        send(8'h55, 4'd1, 4'd3, 1'b0, 1'b1, 2'd0, 16'h1234, w);
        @(negedge clk);
        check("lint_set_imm", {31'h0, lint_err}, 32'h1);
        tick();
        do_flush();
        wait_done();
`else
        do_start(12'h300);
        tick();
        send(8'h42, 4'd1, 4'd2, 1'b0, 1'b0, 2'd0, 16'h0001, w);
        send(8'h55, 4'd1, 4'd3, 1'b0, 1'b1, 2'd0, 16'h1234, w);
        @(negedge clk);
        check("lint_tied_low", {31'h0, lint_err}, 32'h0);
        tick();
        do_flush();
        wait_done();
`endif
        tick(); tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
